// File: rtl/mips_cpu_muldiv.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO pair.
// Shift-add multiply and restoring divide share one 2*WIDTH working register.
module mips_cpu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_content,
    input  logic [WIDTH-1:0] rt_content,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opd;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dbz;

    logic               signed_op;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        rs_neg    = signed_op & rs_content[WIDTH-1];
        rt_neg    = signed_op & rt_content[WIDTH-1];
        rs_mag    = rs_neg ? -rs_content : rs_content;
        rt_mag    = rt_neg ? -rt_content : rt_content;
        // acc = {partial product, multiplier} for MUL, {remainder, dividend/quotient} for DIV
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opd : '0)};
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opd};
        prod_fix  = neg_q ? -acc : acc;
        q_fix     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            opd         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                OP_MULT, OP_MULTU: begin
                                    acc    <= {{WIDTH{1'b0}}, rt_mag};
                                    opd    <= rs_mag;
                                    neg_q  <= rs_neg ^ rt_neg;
                                    neg_r  <= 1'b0;
                                    is_div <= 1'b0;
                                    dbz    <= 1'b0;
                                    cnt    <= '0;
                                    state  <= RUN;
                                    busy   <= 1'b1;
                                end
                                OP_DIV, OP_DIVU: begin
                                    is_div <= 1'b1;
                                    busy   <= 1'b1;
                                    cnt    <= '0;
                                    if (rt_content == '0) begin
                                        // raw dividend parked so FIX can return it in HI
                                        acc   <= {{WIDTH{1'b0}}, rs_content};
                                        dbz   <= 1'b1;
                                        state <= FIX;
                                    end else begin
                                        acc   <= {{WIDTH{1'b0}}, rs_mag};
                                        opd   <= rt_mag;
                                        neg_q <= rs_neg ^ rt_neg;
                                        neg_r <= rs_neg;
                                        dbz   <= 1'b0;
                                        state <= RUN;
                                    end
                                end
                                OP_MTHI: hi <= rs_content;
                                OP_MTLO: lo <= rs_content;
                                default: ;
                            endcase
                        end
                    end
                    RUN: begin
                        cnt <= cnt + CNT_W'(1);
                        if (is_div) begin
                            if (!div_trial[WIDTH])
                                acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                            else
                                acc <= {acc[2*WIDTH-2:0], 1'b0};
                        end else begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        end
                        if (cnt == CNT_W'(WIDTH - 1))
                            state <= FIX;
                    end
                    FIX: begin
                        if (dbz) begin
                            hi          <= acc[WIDTH-1:0];
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else if (is_div) begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: arithmetic reference model compared every
// cycle, plus hand-computed literal results and latencies.
module tb_mips_cpu_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] rs = '0;
    logic [W-1:0] rt = '0;
    logic         flush = 1'b0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mips_cpu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .rs_content(rs), .rt_content(rt), .flush(flush),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results from plain arithmetic, timing as a countdown.
    logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic         p_dbz = 1'b0;
    int           m_left = 0;
    longint       sa, sb, sq, sr;
    logic [63:0]  prod;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_dbz = 0; m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            m_done = 0; m_dbz = 0;
            if (flush) begin
                m_left = 0; m_busy = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1; m_dbz = p_dbz; m_busy = 0;
                end
            end else if (start) begin
                case (op)
                    3'd0, 3'd1: begin
                        if (op == 3'd0) begin
                            sa = longint'($signed(rs)); sb = longint'($signed(rt));
                            prod = 64'(sa * sb);
                        end else begin
                            prod = {32'b0, rs} * {32'b0, rt};
                        end
                        p_hi = prod[63:32]; p_lo = prod[31:0]; p_dbz = 0;
                        m_left = W + 1; m_busy = 1;
                    end
                    3'd2, 3'd3: begin
                        if (rt == '0) begin
                            p_hi = rs; p_lo = '1; p_dbz = 1; m_left = 1;
                        end else begin
                            if (op == 3'd2) begin
                                sa = longint'($signed(rs)); sb = longint'($signed(rt));
                            end else begin
                                sa = longint'({32'b0, rs}); sb = longint'({32'b0, rt});
                            end
                            sq = sa / sb; sr = sa % sb;
                            p_lo = sq[31:0]; p_hi = sr[31:0]; p_dbz = 0; m_left = W + 1;
                        end
                        m_busy = 1;
                    end
                    3'd4: m_hi = rs;
                    3'd5: m_lo = rs;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
    end

    // Called at posedge+1; returns in the done cycle at posedge+1.
    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edbz, input int elat);
        int n;
        start = 1'b1; op = o; rs = a; rt = b;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done_seen"}, 64'(done), 64'd1);
        check({name, "_latency"}, 64'(n), 64'(elat));
        check({name, "_hi"}, 64'(hi), 64'(ehi));
        check({name, "_lo"}, 64'(lo), 64'(elo));
        check({name, "_dbz"}, 64'(div_by_zero), 64'(edbz));
        check({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic issue_one(input logic [2:0] o, input logic [W-1:0] a, input logic fl);
        start = 1'b1; op = o; rs = a; flush = fl;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
    endtask

    initial begin
        int dn;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
        run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
        issue_one(3'd5, 32'h12345678, 1'b0);
        check("mtlo_lo", 64'(lo), 64'h12345678);
        check("mtlo_hi", 64'(hi), 64'hFFFFFFFF);
        check("mtlo_done", 64'(done), 64'd0);

        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        run_op("divu", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 33);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33);
        run_op("div_negdiv", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 33);
        run_op("divu_zero", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1);
        run_op("multu_small", 3'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33);

        // flush mid-RUN, with an MTHI attempted while busy
        start = 1'b1; op = 3'd1; rs = 32'd2; rt = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        issue_one(3'd4, 32'h0000DEAD, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        dn = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("flush_no_done", 64'(dn), 64'd0);
        check("flush_hi", 64'(hi), 64'd0);
        check("flush_lo", 64'(lo), 64'd6);

        // flush on the FIX edge suppresses the write
        start = 1'b1; op = 3'd1; rs = 32'h10; rt = 32'h10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fixflush_done", 64'(done), 64'd0);
        check("fixflush_busy", 64'(busy), 64'd0);
        check("fixflush_lo", 64'(lo), 64'd6);

        // flush beats a same-cycle MTHI; reserved op does nothing
        issue_one(3'd4, 32'h0000ABCD, 1'b1);
        check("flush_mthi_hi", 64'(hi), 64'd0);
        issue_one(3'd6, 32'h55555555, 1'b0);
        check("rsvd_busy", 64'(busy), 64'd0);
        check("rsvd_done", 64'(done), 64'd0);
        check("rsvd_hi", 64'(hi), 64'd0);
        check("rsvd_lo", 64'(lo), 64'd6);

        // async reset mid-RUN
        start = 1'b1; op = 3'd3; rs = 32'd100; rt = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        dn = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("arst_no_done", 64'(dn), 64'd0);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
